// File: rtl/multiplicador_shift_add.sv
// multiplicador_shift_add: sequential shift-add unsigned multiplier; define MULT_TERMINO_ANTECIPADO_EN for early termination
module multiplicador_shift_add #(
  parameter int WIDTH = 4
) (
  input  logic               Clock_i,
  input  logic               Reset_i,
  input  logic               Iniciar_i,
  input  logic [WIDTH-1:0]   OperandoA_i,
  input  logic [WIDTH-1:0]   OperandoB_i,
  output logic [2*WIDTH-1:0] Produto_o,
  output logic               Pronto_o,
  output logic               Ocupado_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] OCIOSO       = 2'd0;
  localparam logic [1:0] SOMA_DESLOCA = 2'd1;
  localparam logic [1:0] CONCLUIDO    = 2'd2;
  localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);
  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] produto_q, produto_d;
  logic               pronto_q, pronto_d;
  logic               ocupado_q, ocupado_d;
  logic               fim;
`ifdef MULT_TERMINO_ANTECIPADO_EN
  // leave as soon as no set multiplier bits remain to be consumed
  assign fim = (cnt_q == ULTIMO) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign fim = (cnt_q == ULTIMO);
`endif
  // next-state: one partial product per clock while in SOMA_DESLOCA
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    produto_d = produto_q;
    pronto_d  = 1'b0;
    ocupado_d = ocupado_q;
    case (state_q)
      OCIOSO: if (Iniciar_i) begin
        acc_d     = '0;
        mcand_d   = {{WIDTH{1'b0}}, OperandoA_i};
        mplier_d  = OperandoB_i;
        cnt_d     = '0;
        ocupado_d = 1'b1;
        state_d   = SOMA_DESLOCA;
      end
      SOMA_DESLOCA: begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = fim ? CONCLUIDO : SOMA_DESLOCA;
      end
      CONCLUIDO: begin
        produto_d = acc_q;
        pronto_d  = 1'b1;
        ocupado_d = 1'b0;
        state_d   = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end
  // state registers; reset aborts any operation in flight
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q   <= OCIOSO;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      produto_q <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      produto_q <= produto_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end
  assign Produto_o = produto_q;
  assign Pronto_o  = pronto_q;
  assign Ocupado_o = ocupado_q;
endmodule
